// File: rtl/sa_tile_engine_if.sv
// Operand/result handshake bundle for the systolic MAC tile.
// master drives jobs, operands and result backpressure; slave is the engine.
interface sa_tile_engine_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 19,
  parameter int unsigned KW   = 8
);
  localparam int unsigned IW = $clog2(ROWS);

  logic                 EN;
  logic                 START;
  logic [KW-1:0]        K_LEN;
  logic                 BUSY;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic [ROWS*DW-1:0]   A_VEC;
  logic [COLS*DW-1:0]   B_VEC;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [COLS*AW-1:0]   OUT_ROW;
  logic [IW-1:0]        OUT_ROW_IDX;
  logic                 DONE;

  modport master (
    output EN, START, K_LEN, IN_VALID, A_VEC, B_VEC, OUT_READY,
    input  BUSY, IN_READY, OUT_VALID, OUT_ROW, OUT_ROW_IDX, DONE
  );

  modport slave (
    input  EN, START, K_LEN, IN_VALID, A_VEC, B_VEC, OUT_READY,
    output BUSY, IN_READY, OUT_VALID, OUT_ROW, OUT_ROW_IDX, DONE
  );
endinterface

// File: rtl/sa_tile_engine.sv
// Output-stationary ROWS x COLS systolic MAC tile with built-in operand skew,
// job sequencing FSM and a row-serial valid/ready result drain.
module sa_tile_engine #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 19,
  parameter int unsigned KW     = 8,
  parameter bit          SIGNED = 1'b0
) (
  input logic             CLK,
  input logic             RST,
  sa_tile_engine_if.slave bus
);
  localparam int unsigned IW = $clog2(ROWS);
  localparam int unsigned FW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e             state_q;
  logic [KW-1:0]      beat_cnt_q;
  logic [FW-1:0]      flush_cnt_q;
  logic               out_valid_q;
  logic               done_q;
  logic [COLS*AW-1:0] out_row_q;
  logic [IW-1:0]      out_idx_q;

  logic               in_ready;
  logic               fire;
  logic               clear_acc;
  logic               accum;
  logic [ROWS*DW-1:0] a_edge;
  logic [COLS*DW-1:0] b_edge;
  logic [IW-1:0]      next_idx;
  logic [COLS*AW-1:0] row_next;

  logic [DW-1:0]      a_q   [ROWS][COLS];
  logic [DW-1:0]      b_q   [ROWS][COLS];
  logic [AW-1:0]      acc_q [ROWS][COLS];
  logic [2*DW-1:0]    mul   [ROWS][COLS];
  logic [AW-1:0]      prod  [ROWS][COLS];

  assign in_ready  = bus.EN & (state_q == StLoad);
  assign fire      = in_ready & bus.IN_VALID;
  assign clear_acc = bus.EN & (state_q == StIdle) & bus.START;
  assign accum     = (state_q == StLoad) | (state_q == StFlush);

  // Row i enters the grid i cycles late; unaccepted cycles inject zeros.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic [DW-1:0] a_in;
    assign a_in = fire ? bus.A_VEC[i*DW +: DW] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i*DW +: DW] = a_in;
    end else begin : g_delay
      logic [DW-1:0] sr_q [i];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int k = 0; k < i; k++) sr_q[k] <= '0;
        end else if (bus.EN) begin
          sr_q[0] <= a_in;
          for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign a_edge[i*DW +: DW] = sr_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic [DW-1:0] b_in;
    assign b_in = fire ? bus.B_VEC[j*DW +: DW] : '0;
    if (j == 0) begin : g_direct
      assign b_edge[j*DW +: DW] = b_in;
    end else begin : g_delay
      logic [DW-1:0] sr_q [j];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int k = 0; k < j; k++) sr_q[k] <= '0;
        end else if (bus.EN) begin
          sr_q[0] <= b_in;
          for (int k = 1; k < j; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign b_edge[j*DW +: DW] = sr_q[j-1];
    end
  end

  // Operands are extended to 2*DW before multiplying so the full product is kept.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        mul[i][j] = {{DW{SIGNED & a_q[i][j][DW-1]}}, a_q[i][j]} *
                    {{DW{SIGNED & b_q[i][j][DW-1]}}, b_q[i][j]};
        prod[i][j] = AW'(mul[i][j]);
        if (SIGNED) prod[i][j] = AW'($signed(mul[i][j]));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else if (bus.EN) begin
      for (int i = 0; i < ROWS; i++) a_q[i][0] <= a_edge[i*DW +: DW];
      for (int j = 0; j < COLS; j++) b_q[0][j] <= b_edge[j*DW +: DW];
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 1; j < COLS; j++) a_q[i][j] <= a_q[i][j-1];
      end
      for (int i = 1; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) b_q[i][j] <= b_q[i-1][j];
      end
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          if (clear_acc) begin
            acc_q[i][j] <= '0;
          end else if (accum) begin
            acc_q[i][j] <= acc_q[i][j] + prod[i][j];
          end
        end
      end
    end
  end

  // First drain cycle presents row 0; afterwards each handshake advances one row.
  always_comb begin
    next_idx = out_valid_q ? out_idx_q + IW'(1) : '0;
    row_next = '0;
    for (int j = 0; j < COLS; j++) row_next[j*AW +: AW] = acc_q[next_idx][j];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else if (bus.EN) begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.START) begin
            beat_cnt_q  <= bus.K_LEN;
            flush_cnt_q <= FW'(ROWS + COLS - 2);
            state_q     <= (bus.K_LEN == '0) ? StFlush : StLoad;
          end
        end
        StLoad: begin
          if (fire) begin
            beat_cnt_q <= beat_cnt_q - KW'(1);
            if (beat_cnt_q == KW'(1)) state_q <= StFlush;
          end
        end
        StFlush: begin
          if (flush_cnt_q == '0) begin
            state_q <= StDrain;
          end else begin
            flush_cnt_q <= flush_cnt_q - FW'(1);
          end
        end
        StDrain: begin
          if (!out_valid_q || bus.OUT_READY) begin
            if (out_valid_q && (out_idx_q == IW'(ROWS - 1))) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StIdle;
            end else begin
              out_valid_q <= 1'b1;
              out_idx_q   <= next_idx;
              out_row_q   <= row_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.BUSY        = (state_q != StIdle);
  assign bus.IN_READY    = in_ready;
  assign bus.OUT_VALID   = out_valid_q;
  assign bus.OUT_ROW     = out_row_q;
  assign bus.OUT_ROW_IDX = out_idx_q;
  assign bus.DONE        = done_q;
endmodule
